fft_power_spectrum: RTL and testbench
=====================================

Name: fft_power_spectrum

Overview:
Downstream consumer of the FFT core's serial result stream. Each frame is 64 signed words: bins 0..31 real parts first, then bins 0..31 imaginary parts. The block buffers the real half, computes per-bin power re^2+im^2 as the imaginary half arrives, and streams power per bin. It also reports the peak bin of each frame for the detection logic behind it.

Parameters:
N, 32, FFT points per frame (power of two); the frame is 2*N words
IN_W, 17, width of signed two's-complement input word
OUT_W, 34, width of unsigned power output; values above 2^OUT_W-1 saturate
IDX_W, 5, bin index width, equal to log2(N)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
valid_i  input  1  input word qualifier; driven by the FFT core's finish
data_i  input  IN_W  signed FFT output word; driven by the FFT core's answer
pwr_valid_o  output  1  pwr_o and pwr_idx_o are valid this cycle
pwr_o  output  OUT_W  re^2+im^2 of bin pwr_idx_o, saturated
pwr_idx_o  output  IDX_W  bin index of pwr_o
peak_valid_o  output  1  one-cycle pulse: peak result of the completed frame
peak_idx_o  output  IDX_W  bin with the largest power; held until the next pulse
peak_pwr_o  output  OUT_W  power of that bin; held until the next pulse
busy_o  output  1  high from the first accepted word until the frame's peak_valid_o

Behaviour:
- Reset: all outputs are 0. Word counter and state are cleared. The real buffer is not cleared.
- Assertion of rst mid-frame aborts the frame immediately. No partial pwr or peak output is produced.
- Word counter wcnt spans 0..2N-1 and advances only on cycles with valid_i=1. Gaps of any length are allowed.
- At wcnt=2N-1 the counter wraps to 0. A new frame may start on the very next cycle; the pipeline tolerates back-to-back frames.
- FSM states: COLLECT_RE, COLLECT_IM.
  - COLLECT_RE: data_i is written to re_buf[wcnt]. After word N-1 is accepted, move to COLLECT_IM.
  - COLLECT_IM: each accepted word k=wcnt-N is paired with re_buf[k] and sent into the power pipe. After word 2N-1 is accepted, return to COLLECT_RE.
- Power pipe, 2 stages:
  - S1 registers re^2 and im^2, each unsigned 2*IN_W-1 bits.
  - S2 registers the sum, 2*IN_W bits, saturated to OUT_W.
  - pwr_valid_o asserts exactly 2 cycles after the imaginary word is sampled. pwr_o/pwr_idx_o hold their value when pwr_valid_o=0.
- Extreme case: re=im=-2^(IN_W-1) gives 2^(2*IN_W-1), which fits in the default OUT_W=34 without saturation.
- Peak tracker, evaluated on each pwr_valid_o:
  - Bin 0 loads the running peak unconditionally.
  - Later bins replace the running peak only if strictly greater, so ties keep the lowest index.
  - The cycle after bin N-1 output: peak_valid_o pulses for one cycle, peak_idx_o/peak_pwr_o update, and busy_o falls unless a new frame has started.
- The running peak is separate from the peak outputs. A peak pulse from the old frame may coincide with S1 of the new frame; both proceed.

Optional Feature:
FFT_PWR_DC_SKIP_EN
- Defined: bin 0 is excluded from the peak search. Bin 1 loads the running peak unconditionally, and peak_idx_o is never 0. pwr_o for bin 0 is still emitted.
- Undefined: the peak search covers all bins as described in Behaviour.

Decomposition:
- Shared package fft_pkg holds:
  - N, IN_W, OUT_W, IDX_W defaults
  - FSM state enum
  - saturation function sat_pwr()
- One sub-module, fft_pwr_pipe: the 2-stage square/sum/saturate datapath, with valid and index carried alongside.
- The FSM, buffer, and peak tracker stay in the top level.

Test Plan:
- Frame with all re=1, im=0 → 32 pwr_valid_o pulses, each pwr_o=1 with idx 0..31 in order; peak_idx_o=0, peak_pwr_o=1.
- Bin 5 set to re=-65536, im=-65536, all others 0 → pwr_o[5]=8589934592, peak_idx_o=5; first pwr_valid_o 2 cycles after word 32 is sampled.
- Bins 3 and 9 both with re=100, im=0, all others 0 → peak_idx_o=3, peak_pwr_o=10000.
- Same frame as the bin-5 case, with valid_i gapped for 3 cycles after every 7 words → identical pwr and peak values; only the timing shifts.
- rst pulsed at word 40, then a clean frame (bin 2: re=3, im=4) → no outputs from the aborted frame; clean frame gives pwr_o[2]=25, peak_idx_o=2.
- With OUT_W=16, bin 1 at re=300, im=0 → pwr_o=65535 (saturated). With FFT_PWR_DC_SKIP_EN defined, bin 0 re=50 and bin 7 re=2 → peak_idx_o=7, peak_pwr_o=4.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fft_pkg
//  Description : Shared defaults, FSM state type and power saturation helper
//                for the FFT power-spectrum block.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int N_DEF     = 32;
    localparam int IN_W_DEF  = 17;
    localparam int OUT_W_DEF = 34;
    localparam int IDX_W_DEF = 5;

    typedef enum logic [0:0] {
        COLLECT_RE = 1'b0,
        COLLECT_IM = 1'b1
    } fft_state_t;

    // Clamp an unsigned power value to the largest value representable in
    // out_w bits. The caller truncates the result to out_w bits.
    function automatic logic [63:0] sat_pwr(input logic [63:0] sum, input int out_w);
        logic [63:0] max_v;
        max_v = (out_w >= 64) ? '1 : ((64'd1 << out_w) - 64'd1);
        return (sum > max_v) ? max_v : sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_pwr_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pwr_pipe
//  Description : Two-stage power datapath. Stage 1 squares the real and
//                imaginary parts, stage 2 adds them and saturates to OUT_W.
//                Valid and bin index travel alongside the data; the outputs
//                hold their last value while out_valid is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_pwr_pipe
    import fft_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  re,
    input  logic signed [IN_W-1:0]  im,
    input  logic [IDX_W-1:0]        in_idx,
    output logic                    out_valid,
    output logic [OUT_W-1:0]        pwr,
    output logic [IDX_W-1:0]        out_idx
);

    // A square of an IN_W-bit signed value is at most 2^(2*IN_W-2), so it
    // fits in 2*IN_W-1 unsigned bits; the sum of two needs one more bit.
    localparam int SQ_W  = 2 * IN_W - 1;
    localparam int SUM_W = 2 * IN_W;

    logic signed [SUM_W-1:0] re_ext;
    logic signed [SUM_W-1:0] im_ext;
    logic [SQ_W-1:0]         re_sq_d;
    logic [SQ_W-1:0]         im_sq_d;

    logic                    s1_valid;
    logic [IDX_W-1:0]        s1_idx;
    logic [SQ_W-1:0]         re_sq;
    logic [SQ_W-1:0]         im_sq;

    logic [SUM_W-1:0]        sum;
    logic [OUT_W-1:0]        sum_sat;

    assign re_ext  = SUM_W'(re);
    assign im_ext  = SUM_W'(im);
    assign re_sq_d = SQ_W'(re_ext * re_ext);
    assign im_sq_d = SQ_W'(im_ext * im_ext);

    assign sum     = SUM_W'(re_sq) + SUM_W'(im_sq);
    assign sum_sat = OUT_W'(sat_pwr(64'(sum), OUT_W));

    // Stage 1: register both squares with the bin index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            re_sq    <= '0;
            im_sq    <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_idx <= in_idx;
                re_sq  <= re_sq_d;
                im_sq  <= im_sq_d;
            end
        end
    end

    // Stage 2: register the saturated sum; data holds while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            pwr       <= '0;
            out_idx   <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                pwr     <= sum_sat;
                out_idx <= s1_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_power_spectrum.sv
`default_nettype none
// ============================================================================
//  Module      : fft_power_spectrum
//  Description : Consumes the FFT serial result stream (N real words, then
//                N imaginary words per frame), streams per-bin power
//                re^2+im^2 and reports the peak bin of every frame.
//                Optional macro FFT_PWR_DC_SKIP_EN excludes bin 0 from the
//                peak search (bin 0 power is still streamed).
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_power_spectrum
    import fft_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic signed [IN_W-1:0]  data_i,
    output logic                    pwr_valid_o,
    output logic [OUT_W-1:0]        pwr_o,
    output logic [IDX_W-1:0]        pwr_idx_o,
    output logic                    peak_valid_o,
    output logic [IDX_W-1:0]        peak_idx_o,
    output logic [OUT_W-1:0]        peak_pwr_o,
    output logic                    busy_o
);

    localparam int WCNT_W = IDX_W + 1;

`ifdef FFT_PWR_DC_SKIP_EN
    localparam int FIRST_BIN = 1;
`else
    localparam int FIRST_BIN = 0;
`endif

    localparam logic [WCNT_W-1:0] LAST_RE   = WCNT_W'(N - 1);
    localparam logic [WCNT_W-1:0] LAST_IM   = WCNT_W'(2 * N - 1);
    localparam logic [IDX_W-1:0]  FIRST_IDX = IDX_W'(FIRST_BIN);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);

    fft_state_t              state;
    fft_state_t              state_next;
    logic [WCNT_W-1:0]       wcnt;
    logic [IDX_W-1:0]        bin;
    logic signed [IN_W-1:0]  re_buf [N];
    logic                    pipe_valid;

    logic                    take;
    logic                    frame_end;
    logic                    frame_open;
    logic [IDX_W-1:0]        cand_idx;
    logic [OUT_W-1:0]        cand_pwr;
    logic [IDX_W-1:0]        run_idx;
    logic [OUT_W-1:0]        run_pwr;

    assign bin        = wcnt[IDX_W-1:0];
    assign pipe_valid = valid_i && (state == COLLECT_IM);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT_RE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: switch halves after the last word of each half
    always_comb begin
        state_next = state;
        case (state)
            COLLECT_RE: if (valid_i && (wcnt == LAST_RE)) state_next = COLLECT_IM;
            COLLECT_IM: if (valid_i && (wcnt == LAST_IM)) state_next = COLLECT_RE;
            default:    state_next = COLLECT_RE;
        endcase
    end

    // Word counter over the whole frame, advancing only on accepted words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else if (valid_i) begin
            wcnt <= (wcnt == LAST_IM) ? '0 : wcnt + WCNT_W'(1);
        end
    end

    // Real-part buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (valid_i && (state == COLLECT_RE)) begin
            re_buf[bin] <= data_i;
        end
    end

    fft_pwr_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .IDX_W (IDX_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pipe_valid),
        .re        (re_buf[bin]),
        .im        (data_i),
        .in_idx    (bin),
        .out_valid (pwr_valid_o),
        .pwr       (pwr_o),
        .out_idx   (pwr_idx_o)
    );

    // Peak candidate: first searched bin loads, later bins must be strictly
    // greater so ties keep the lowest index
    always_comb begin
        take      = (pwr_idx_o == FIRST_IDX) ||
                    ((pwr_idx_o > FIRST_IDX) && (pwr_o > run_pwr));
        cand_idx  = take ? pwr_idx_o : run_idx;
        cand_pwr  = take ? pwr_o     : run_pwr;
        frame_end = pwr_valid_o && (pwr_idx_o == LAST_IDX);
        frame_open = valid_i || (wcnt != '0);
    end

    // Running peak over the frame currently leaving the pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_idx <= '0;
            run_pwr <= '0;
        end else if (pwr_valid_o) begin
            run_idx <= cand_idx;
            run_pwr <= cand_pwr;
        end
    end

    // Peak result registers, updated once per completed frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_valid_o <= 1'b0;
            peak_idx_o   <= '0;
            peak_pwr_o   <= '0;
        end else begin
            peak_valid_o <= frame_end;
            if (frame_end) begin
                peak_idx_o <= cand_idx;
                peak_pwr_o <= cand_pwr;
            end
        end
    end

    // Busy: set by accepted words, cleared with the peak pulse unless the
    // next frame is already underway
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_o <= 1'b0;
        end else if (frame_end) begin
            busy_o <= frame_open;
        end else if (valid_i) begin
            busy_o <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_power_spectrum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_power_spectrum
//  Description : Self-checking bench for fft_power_spectrum. A 34-bit and a
//                16-bit output instance share the stimulus; a frame-level
//                model predicts every power word, its cycle, and the peak.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_power_spectrum;

    localparam int NB = 32;

    typedef struct {
        longint pa;
        longint pb;
        int     idx;
        longint cyc;
    } pitem_t;

    typedef struct {
        int     ia;
        longint pa;
        int     ib;
        longint pb;
        longint cyc;
    } kitem_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid_i = 1'b0;
    logic signed [16:0] data_i = '0;

    logic        pv_a, kv_a, busy_a;
    logic [33:0] pwr_a, kpwr_a;
    logic [4:0]  pidx_a, kidx_a;
    logic        pv_b, kv_b, busy_b;
    logic [15:0] pwr_b, kpwr_b;
    logic [4:0]  pidx_b, kidx_b;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    int     re_v [NB];
    int     im_v [NB];
    pitem_t pq [$];
    kitem_t kq [$];
    pitem_t pit;
    kitem_t kit;

    fft_power_spectrum dut_a (
        .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i),
        .pwr_valid_o(pv_a), .pwr_o(pwr_a), .pwr_idx_o(pidx_a),
        .peak_valid_o(kv_a), .peak_idx_o(kidx_a), .peak_pwr_o(kpwr_a),
        .busy_o(busy_a)
    );

    fft_power_spectrum #(.OUT_W(16)) dut_b (
        .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i),
        .pwr_valid_o(pv_b), .pwr_o(pwr_b), .pwr_idx_o(pidx_b),
        .peak_valid_o(kv_b), .peak_idx_o(kidx_b), .peak_pwr_o(kpwr_b),
        .busy_o(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint sat(input longint p, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (p > mx) ? mx : p;
    endfunction

    function automatic longint bin_pwr(input int k);
        return longint'(re_v[k]) * re_v[k] + longint'(im_v[k]) * im_v[k];
    endfunction

    // Peak of the frame in re_v/im_v after saturation to w bits
    function automatic void frame_peak(input int w, output int idx, output longint p);
        int first;
`ifdef FFT_PWR_DC_SKIP_EN
        first = 1;
`else
        first = 0;
`endif
        idx = first;
        p   = sat(bin_pwr(first), w);
        for (int k = first + 1; k < NB; k++) begin
            if (sat(bin_pwr(k), w) > p) begin
                idx = k;
                p   = sat(bin_pwr(k), w);
            end
        end
    endfunction

    // Every-cycle comparison against the model queues
    always @(negedge clk) begin
        if (!rst) begin
            if (pv_a || pv_b) begin
                if (pq.size() == 0) begin
                    chk("pwr_unexpected", 1, 0);
                end else begin
                    pit = pq.pop_front();
                    chk("pwr_valid_a", pv_a, 1);
                    chk("pwr_valid_b", pv_b, 1);
                    chk("pwr_cycle", cyc, pit.cyc);
                    chk("pwr_idx_a", pidx_a, pit.idx);
                    chk("pwr_idx_b", pidx_b, pit.idx);
                    chk("pwr_a", pwr_a, pit.pa);
                    chk("pwr_b", pwr_b, pit.pb);
                end
            end else if (pq.size() != 0 && pq[0].cyc <= cyc) begin
                pit = pq.pop_front();
                chk("pwr_missing_at_cycle", cyc, -1);
            end
            if (kv_a || kv_b) begin
                if (kq.size() == 0) begin
                    chk("peak_unexpected", 1, 0);
                end else begin
                    kit = kq.pop_front();
                    chk("peak_valid_a", kv_a, 1);
                    chk("peak_valid_b", kv_b, 1);
                    chk("peak_cycle", cyc, kit.cyc);
                    chk("peak_idx_a", kidx_a, kit.ia);
                    chk("peak_pwr_a", kpwr_a, kit.pa);
                    chk("peak_idx_b", kidx_b, kit.ib);
                    chk("peak_pwr_b", kpwr_b, kit.pb);
                end
            end else if (kq.size() != 0 && kq[0].cyc <= cyc) begin
                kit = kq.pop_front();
                chk("peak_missing_at_cycle", cyc, -1);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        valid_i = 1'b0;
        pq.delete();
        kq.delete();
        #1;
        chk("rst_pwr_valid", pv_a, 0);
        chk("rst_pwr", pwr_a, 0);
        chk("rst_pwr_idx", pidx_a, 0);
        chk("rst_peak_valid", kv_a, 0);
        chk("rst_peak_idx", kidx_a, 0);
        chk("rst_peak_pwr", kpwr_a, 0);
        chk("rst_busy", busy_a, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // gap_mode 0: none, 1: 3 idle cycles after every 7 words, 2: random
    task automatic send_frame(input int gap_mode, input int abort_at);
        pitem_t pi;
        kitem_t ki;
        int ng;
        for (int w = 0; w < 2 * NB; w++) begin
            ng = 0;
            if (gap_mode == 1 && w != 0 && (w % 7) == 0) ng = 3;
            if (gap_mode == 2 && $urandom_range(0, 3) == 0) ng = $urandom_range(1, 4);
            for (int g = 0; g < ng; g++) begin
                @(posedge clk);
                #1;
                valid_i = 1'b0;
            end
            if (w == abort_at) begin
                do_reset();
                return;
            end
            if (w == 10) chk("busy_mid_frame", busy_a, 1);
            @(posedge clk);
            #1;
            valid_i = 1'b1;
            data_i  = (w < NB) ? 17'(re_v[w]) : 17'(im_v[w - NB]);
            if (w >= NB) begin
                pi.pa  = sat(bin_pwr(w - NB), 34);
                pi.pb  = sat(bin_pwr(w - NB), 16);
                pi.idx = w - NB;
                pi.cyc = cyc + 2;
                pq.push_back(pi);
            end
            if (w == 2 * NB - 1) begin
                frame_peak(34, ki.ia, ki.pa);
                frame_peak(16, ki.ib, ki.pb);
                ki.cyc = cyc + 3;
                kq.push_back(ki);
            end
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("busy_idle", busy_a, 0);
    endtask

    task automatic clear_frame();
        for (int k = 0; k < NB; k++) begin
            re_v[k] = 0;
            im_v[k] = 0;
        end
    endtask

    task automatic rand_frame();
        for (int k = 0; k < NB; k++) begin
            case ($urandom_range(0, 3))
                0:       re_v[k] = -65536;
                1:       re_v[k] = int'($urandom_range(0, 600)) - 300;
                default: re_v[k] = int'($urandom_range(0, 131071)) - 65536;
            endcase
            im_v[k] = ($urandom_range(0, 4) == 0) ? -65536 : int'($urandom_range(0, 131071)) - 65536;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=%0d expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // all re=1, im=0
        for (int k = 0; k < NB; k++) begin
            re_v[k] = 1;
            im_v[k] = 0;
        end
        send_frame(0, -1);
        go_idle();
        chk("lit_ones_peak_idx", kidx_a, 0);
        chk("lit_ones_peak_pwr", kpwr_a, 1);

        // bin 5 at the most negative value
        clear_frame();
        re_v[5] = -65536;
        im_v[5] = -65536;
        send_frame(0, -1);
        go_idle();
        chk("lit_bin5_peak_idx", kidx_a, 5);
        chk("lit_bin5_peak_pwr", kpwr_a, 64'd8589934592);
        chk("lit_bin5_peak_pwr_sat16", kpwr_b, 65535);

        // tie between bins 3 and 9
        clear_frame();
        re_v[3] = 100;
        re_v[9] = 100;
        send_frame(0, -1);
        go_idle();
        chk("lit_tie_peak_idx", kidx_a, 3);
        chk("lit_tie_peak_pwr", kpwr_a, 10000);

        // bin 5 again with 3-cycle gaps after every 7 words
        clear_frame();
        re_v[5] = -65536;
        im_v[5] = -65536;
        send_frame(1, -1);
        go_idle();
        chk("lit_gap_peak_idx", kidx_a, 5);
        chk("lit_gap_peak_pwr", kpwr_a, 64'd8589934592);

        // abort at word 40, then a clean frame
        rand_frame();
        send_frame(0, 40);
        clear_frame();
        re_v[2] = 3;
        im_v[2] = 4;
        send_frame(0, -1);
        go_idle();
        chk("lit_clean_peak_idx", kidx_a, 2);
        chk("lit_clean_peak_pwr", kpwr_a, 25);

        // saturation in the 16-bit instance
        clear_frame();
        re_v[1] = 300;
        send_frame(0, -1);
        go_idle();
        chk("lit_sat_peak_pwr16", kpwr_b, 65535);
        chk("lit_sat_peak_idx16", kidx_b, 1);
        chk("lit_sat_peak_pwr34", kpwr_a, 90000);

        // DC bin dominant
        clear_frame();
        re_v[0] = 50;
        re_v[7] = 2;
        send_frame(0, -1);
        go_idle();
`ifdef FFT_PWR_DC_SKIP_EN
        chk("lit_dc_peak_idx", kidx_a, 7);
        chk("lit_dc_peak_pwr", kpwr_a, 4);
`else
        chk("lit_dc_peak_idx", kidx_a, 0);
        chk("lit_dc_peak_pwr", kpwr_a, 2500);
`endif

        // random frames, back-to-back, some with random gaps
        for (int f = 0; f < 8; f++) begin
            rand_frame();
            send_frame((f % 2 == 0) ? 0 : 2, -1);
        end
        go_idle();

        chk("drain_pwr_queue", pq.size(), 0);
        chk("drain_peak_queue", kq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
